mem_stall_ctrl: RTL
===================

// Module: mem_stall_ctrl
// PURPOSE
//  Sequences data-memory accesses in the MEM stage against a variable-latency memory
//  with a req/ack handshake. It freezes the upstream pipeline (PC, IF/ID, ID/EX, EX/MEM)
//  until the access completes. While frozen it injects bubbles into the MEM/WB register
//  and supplies the captured load data to MEM/WB on the release cycle.
// PARAMETERS
//  ADDR_W       32   memory address width
//  DATA_W       32   memory data width
//  TIMEOUT_CYC  255  max BUSY cycles before abort (used only with MEM_TIMEOUT_EN)
// PORTS
//  clk_i        in   1       clock, rising edge
//  rst_i        in   1       async reset, active-high
//  MemRead_i    in   1       EX/MEM load request
//  MemWrite_i   in   1       EX/MEM store request
//  addr_i       in   ADDR_W  EX/MEM ALU result (address)
//  wdata_i      in   DATA_W  EX/MEM store data
//  mem_req_o    out  1       memory request, registered
//  mem_we_o     out  1       1=write, 0=read; valid while mem_req_o
//  mem_addr_o   out  ADDR_W  latched address
//  mem_wdata_o  out  DATA_W  latched store data
//  mem_ack_i    in   1       memory completion, 1-cycle pulse
//  mem_rdata_i  in   DATA_W  load data, valid with mem_ack_i
//  stall_o      out  1       freeze PC/IF_ID/ID_EX/EX_MEM
//  wb_bubble_o  out  1       force MEM/WB RegWrite_i and MemtoReg_i to 0
//  rdata_o      out  DATA_W  load data to MEM/WB ReadData_i
//  busy_o       out  1       FSM not in IDLE
//  err_o        out  1       sticky timeout flag
// BEHAVIOUR
//  Reset: state=IDLE. mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, rdata_o,
//   err_o, and the timeout counter are 0.
//  Reset asserted mid-access drops mem_req_o immediately (async) and discards the access.
//  Access pending: acc = MemRead_i | MemWrite_i. If both are set, treat the access as a write.
//  FSM states:
//   IDLE: if acc -> BUSY. Latch addr/wdata and we=MemWrite_i; set mem_req_o=1 at the edge.
//    stall_o = wb_bubble_o = acc (combinational).
//   BUSY: mem_req_o held high; inputs ignored (pipeline frozen). stall_o=wb_bubble_o=1.
//    On mem_ack_i: mem_req_o<=0; on a read, rdata_o<=mem_rdata_i. -> DONE.
//   DONE: stall_o=wb_bubble_o=0 for exactly one cycle. The pipeline advances and MEM/WB
//    captures rdata_o. -> IDLE unconditionally.
//  A new access in the cycle after DONE is handled normally (back-to-back).
//  mem_ack_i is ignored outside BUSY. Ack arriving in the first BUSY cycle is valid.
//  Minimum latency: access seen at cycle 0, req at 1, ack at 1, release in DONE at 2.
//   Total 3 cycles; general case is ack_delay + 2.
//  A write leaves rdata_o unchanged. rdata_o holds its value until the next read ack.
//  busy_o = (state != IDLE).
// CONFIGURATION
//  MEM_TIMEOUT_EN defined:
//   - A counter increments each BUSY cycle and clears on entering BUSY.
//   - When the count reaches TIMEOUT_CYC without an ack: mem_req_o<=0, rdata_o<=0,
//     err_o<=1 (sticky until reset), then -> DONE.
//   - An ack in the same cycle as the timeout takes priority; no error is raised.
//  MEM_TIMEOUT_EN undefined:
//   - No counter; BUSY waits indefinitely. err_o is tied to 0.
// TESTING
//  1 Reset: rst_i=1 mid-BUSY -> mem_req_o=0 async; after release, state IDLE, err_o=0.
//  2 Load, ack 1 cycle after req, mem_rdata_i=32'hDEADBEEF:
//    stall_o high for 2 cycles, low in DONE; rdata_o=32'hDEADBEEF; wb_bubble_o tracks stall_o.
//  3 Store addr=32'h40, wdata=32'h1234, ack after 5 cycles:
//    mem_we_o=1, mem_addr_o=32'h40, mem_wdata_o=32'h1234 held for the whole req;
//    stall_o high 6 cycles; rdata_o unchanged.
//  4 Back-to-back load then store:
//    second req rises 1 cycle after DONE; stray ack in IDLE is ignored (no state change).
//  5 MEM_TIMEOUT_EN, TIMEOUT_CYC=4, never ack:
//    req drops after 4 BUSY cycles; err_o=1 and stays 1; rdata_o=0; pipeline released.
//  6 MEM_TIMEOUT_EN, ack on the exact timeout cycle -> err_o stays 0 and rdata is captured.

Source files
------------

// File: rtl/mem_stall_if.sv
// mem_stall_if: pipeline/memory-side signal bundle for mem_stall_ctrl
// slave modport  : used by mem_stall_ctrl (takes pipeline requests and memory acks, drives memory and pipeline controls)
// master modport : used by the surrounding pipeline and memory model
// MemRead_i/MemWrite_i/addr_i/wdata_i : EX/MEM access request
// mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o : registered memory request
// mem_ack_i/mem_rdata_i : memory completion pulse and load data
// stall_o/wb_bubble_o/rdata_o/busy_o/err_o : pipeline freeze, MEM/WB bubble, load data, status
interface mem_stall_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              MemRead_i;
  logic              MemWrite_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] wdata_i;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              stall_o;
  logic              wb_bubble_o;
  logic [DATA_W-1:0] rdata_o;
  logic              busy_o;
  logic              err_o;
  modport slave (
    input  MemRead_i, MemWrite_i, addr_i, wdata_i, mem_ack_i, mem_rdata_i,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o, wb_bubble_o, rdata_o, busy_o, err_o
  );
  modport master (
    output MemRead_i, MemWrite_i, addr_i, wdata_i, mem_ack_i, mem_rdata_i,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o, wb_bubble_o, rdata_o, busy_o, err_o
  );
endinterface

// File: rtl/mem_stall_ctrl.sv
// mem_stall_ctrl: MEM-stage sequencer that freezes the pipeline around a variable-latency req/ack memory access
// clk_i : rising-edge clock
// rst_i : asynchronous active-high reset
// bus   : mem_stall_if.slave (pipeline request, memory handshake, stall/bubble/rdata/busy/err)
// Optional feature: define MEM_TIMEOUT_EN to abort an access after TIMEOUT_CYC BUSY cycles and raise sticky err_o.
module mem_stall_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic         clk_i,
  input  logic         rst_i,
  mem_stall_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t            state, state_nx;
  logic              acc, ack, to_hit, err;
  logic              req, we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata, rdata;
  if (TIMEOUT_CYC < 1) begin : g_chk
    $error("TIMEOUT_CYC must be at least 1");
  end
  assign acc = bus.MemRead_i | bus.MemWrite_i;
  // ack only means something while an access is outstanding
  assign ack = (state == BUSY) & bus.mem_ack_i;
`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt <= '0;
    else if (state == IDLE && acc) cnt <= '0;
    else if (state == BUSY) cnt <= cnt + CW'(1);
  end
  // last BUSY cycle of the budget; a simultaneous ack wins
  assign to_hit = (state == BUSY) & ~bus.mem_ack_i & (cnt == CW'(TIMEOUT_CYC - 1));
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err <= 1'b0;
    else if (to_hit) err <= 1'b1;
  end
`else
  assign to_hit = 1'b0;
  assign err    = 1'b0;
`endif
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = (state == IDLE) ? (acc ? BUSY : IDLE) :
               (state == BUSY) ? ((ack | to_hit) ? DONE : BUSY) : IDLE;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req   <= 1'b0;
      we    <= 1'b0;
      addr  <= '0;
      wdata <= '0;
      rdata <= '0;
    end else if (state == IDLE && acc) begin
      req   <= 1'b1;
      we    <= bus.MemWrite_i;
      addr  <= bus.addr_i;
      wdata <= bus.wdata_i;
    end else if (ack) begin
      req <= 1'b0;
      if (!we) rdata <= bus.mem_rdata_i;
    end else if (to_hit) begin
      req   <= 1'b0;
      rdata <= '0;
    end
  end
  // the stall must be combinational in IDLE so the requesting instruction is held on its first cycle
  assign bus.stall_o     = (state == BUSY) | ((state == IDLE) & acc);
  assign bus.wb_bubble_o = bus.stall_o;
  assign bus.busy_o      = state != IDLE;
  assign bus.mem_req_o   = req;
  assign bus.mem_we_o    = we;
  assign bus.mem_addr_o  = addr;
  assign bus.mem_wdata_o = wdata;
  assign bus.rdata_o     = rdata;
  assign bus.err_o       = err;
endmodule
